// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller: default address map,
// region codes and FSM state encoding.
package mem_access_ctrl_pkg;

    localparam int unsigned DefDataW    = 16;
    localparam int unsigned DefAddrW    = 16;
    localparam logic [15:0] DefRam2Top  = 16'h7FFF;
    localparam logic [15:0] DefUartData = 16'hBF00;
    localparam logic [15:0] DefUartStat = 16'hBF01;

    typedef enum logic [1:0] {
        RegRam2,
        RegRam1,
        RegUdata,
        RegUstat
    } region_e;

    typedef enum logic [2:0] {
        StIdle,
        StRamAcc,
        StUartAcc,
        StUartRec,
        StDone
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_addr_decode.sv
// Combinational region decode of a memory-stage address.
// The UART registers sit inside the RAM1 window and take priority over it.
module mem_access_ctrl_addr_decode
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned        ADDR_W    = DefAddrW,
    parameter logic [ADDR_W-1:0]  RAM2_TOP  = DefRam2Top,
    parameter logic [ADDR_W-1:0]  UART_DATA = DefUartData,
    parameter logic [ADDR_W-1:0]  UART_STAT = DefUartStat
) (
    input  logic [ADDR_W-1:0] addr_i,
    output region_e           region_o
);

    // Priority decode: RAM2 window first, then the two UART registers, RAM1 otherwise.
    always_comb begin
        region_o = RegRam1;
        if (addr_i <= RAM2_TOP) begin
            region_o = RegRam2;
        end else if (addr_i == UART_STAT) begin
            region_o = RegUstat;
        end else if (addr_i == UART_DATA) begin
            region_o = RegUdata;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: accepts a load/store in IDLE, runs the SRAM or UART
// bus cycle with registered active-low strobes, and stalls the pipeline until done.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned       DATA_W     = DefDataW,
    parameter int unsigned       ADDR_W     = DefAddrW,
    parameter logic [ADDR_W-1:0] RAM2_TOP   = DefRam2Top,
    parameter logic [ADDR_W-1:0] UART_DATA  = DefUartData,
    parameter logic [ADDR_W-1:0] UART_STAT  = DefUartStat,
    parameter int unsigned       RAM_WAIT   = 1,
    parameter int unsigned       UART_PULSE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              ram1_en_n_o,
    output logic              ram1_oe_n_o,
    output logic              ram1_we_n_o,
    input  logic [DATA_W-1:0] ram1_d_i,
    output logic [DATA_W-1:0] ram1_d_o,
    output logic              ram1_d_oe_o,
    output logic              ram2_en_n_o,
    output logic              ram2_oe_n_o,
    output logic              ram2_we_n_o,
    input  logic [DATA_W-1:0] ram2_d_i,
    output logic [DATA_W-1:0] ram2_d_o,
    output logic              ram2_d_oe_o,
    output logic              uart_rdn_o,
    output logic              uart_wrn_o,
    input  logic              uart_data_ready_i,
    input  logic              uart_tbre_i,
    input  logic              uart_tsre_i
);

    state_e            state_q;
    region_e           region_q;
    region_e           region;
    logic [3:0]        cnt_q;
    logic              is_wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] status_word;

    mem_access_ctrl_addr_decode #(
        .ADDR_W    (ADDR_W),
        .RAM2_TOP  (RAM2_TOP),
        .UART_DATA (UART_DATA),
        .UART_STAT (UART_STAT)
    ) u_addr_decode (
        .addr_i   (addr_i),
        .region_o (region)
    );

    // Status register image: bit 1 receive data ready, bit 0 transmitter fully empty.
    assign status_word = {{(DATA_W-2){1'b0}}, uart_data_ready_i, uart_tbre_i & uart_tsre_i};

    // Write data is only meaningful while the matching d_oe is asserted.
    assign ram1_d_o = wdata_q;
    assign ram2_d_o = wdata_q;

    // Pipeline hold: a fresh request in IDLE, or any access still in flight.
    assign stall_o = ((state_q == StIdle) && (memread_i || memwrite_i)) ||
                     ((state_q != StIdle) && (state_q != StDone));

    // Access FSM with wait counter and registered strobes/result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            region_q      <= RegRam1;
            cnt_q         <= 4'd0;
            is_wr_q       <= 1'b0;
            wdata_q       <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            ram1_en_n_o   <= 1'b1;
            ram1_oe_n_o   <= 1'b1;
            ram1_we_n_o   <= 1'b1;
            ram1_d_oe_o   <= 1'b0;
            ram2_en_n_o   <= 1'b1;
            ram2_oe_n_o   <= 1'b1;
            ram2_we_n_o   <= 1'b1;
            ram2_d_oe_o   <= 1'b0;
            uart_rdn_o    <= 1'b1;
            uart_wrn_o    <= 1'b1;
        end else begin
            rdata_valid_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (memread_i || memwrite_i) begin
                        region_q <= region;
                        is_wr_q  <= memwrite_i;
                        wdata_q  <= wdata_i;
                        unique case (region)
                            RegRam2: begin
                                state_q     <= StRamAcc;
                                cnt_q       <= 4'(RAM_WAIT);
                                ram2_en_n_o <= 1'b0;
                                ram2_oe_n_o <= memwrite_i;
                                ram2_we_n_o <= ~memwrite_i;
                                ram2_d_oe_o <= memwrite_i;
                            end
                            RegRam1: begin
                                state_q     <= StRamAcc;
                                cnt_q       <= 4'(RAM_WAIT);
                                ram1_en_n_o <= 1'b0;
                                ram1_oe_n_o <= memwrite_i;
                                ram1_we_n_o <= ~memwrite_i;
                                ram1_d_oe_o <= memwrite_i;
                            end
                            RegUdata: begin
                                // RAM1 stays deselected; the UART drives the shared bus.
                                state_q     <= StUartAcc;
                                cnt_q       <= 4'(UART_PULSE - 1);
                                uart_rdn_o  <= memwrite_i;
                                uart_wrn_o  <= ~memwrite_i;
                                ram1_d_oe_o <= memwrite_i;
                            end
                            RegUstat: begin
                                // No bus cycle; stores to the status register are dropped.
                                state_q <= StDone;
                                cnt_q   <= 4'd0;
                                if (!memwrite_i) begin
                                    rdata_o       <= status_word;
                                    rdata_valid_o <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                StRamAcc: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= StDone;
                        ram1_en_n_o <= 1'b1;
                        ram1_oe_n_o <= 1'b1;
                        ram1_we_n_o <= 1'b1;
                        ram1_d_oe_o <= 1'b0;
                        ram2_en_n_o <= 1'b1;
                        ram2_oe_n_o <= 1'b1;
                        ram2_we_n_o <= 1'b1;
                        ram2_d_oe_o <= 1'b0;
                        if (!is_wr_q) begin
                            rdata_o       <= (region_q == RegRam2) ? ram2_d_i : ram1_d_i;
                            rdata_valid_o <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StUartAcc: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= StUartRec;
                        uart_rdn_o  <= 1'b1;
                        uart_wrn_o  <= 1'b1;
                        ram1_d_oe_o <= 1'b0;
                        if (!is_wr_q) begin
                            rdata_o <= ram1_d_i;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StUartRec: begin
                    state_q       <= StDone;
                    cnt_q         <= 4'd0;
                    rdata_valid_o <= ~is_wr_q;
                end
                StDone: begin
                    state_q <= StIdle;
                    cnt_q   <= 4'd0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

endmodule
